// File: rtl/ntps_regbank_axi_slave.sv
// AXI4-Lite user-register bank: read-only status words, read/write control words
// with per-word write pulses, and a fixed ID word at the top of the word space.
module ntps_regbank_axi_slave #(
    parameter int                      C_S_AXI_DATA_WIDTH = 32,
    parameter int                      C_S_AXI_ADDR_WIDTH = 8,
    parameter int                      NUM_STATUS         = 16,
    parameter int                      NUM_CTRL           = 8,
    parameter int                      CTRL_BASE          = 32,
    parameter logic [NUM_CTRL*32-1:0]  CTRL_RESET         = '0,
    parameter logic [31:0]             ID_VALUE           = 32'h11a6ebf9
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [NUM_STATUS*32-1:0]        status_in,
    output logic [NUM_CTRL*32-1:0]          ctrl_out,
    output logic [NUM_CTRL-1:0]             ctrl_wr_pulse,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int          IDX_W       = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [31:0] ID_IDX      = 32'((2 ** IDX_W) - 1);
    localparam logic [31:0] STAT_END    = 32'(NUM_STATUS);
    localparam logic [31:0] CTRL_LO     = 32'(CTRL_BASE);
    localparam logic [31:0] CTRL_END    = 32'(CTRL_BASE + NUM_CTRL);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {SEL_NONE, SEL_STATUS, SEL_CTRL, SEL_ID} sel_e;

    function automatic sel_e decode(input logic [IDX_W-1:0] idx);
        logic [31:0] w;
        w = 32'(idx);
        if (w == ID_IDX)                     return SEL_ID;
        if (w < STAT_END)                    return SEL_STATUS;
        if (w >= CTRL_LO && w < CTRL_END)    return SEL_CTRL;
        return SEL_NONE;
    endfunction

    logic                   en_q;
    logic                   aw_full_q, w_full_q;
    logic [IDX_W-1:0]       aw_idx_q;
    logic [31:0]            w_data_q;
    logic [3:0]             w_strb_q;
    logic                   bvalid_q, rvalid_q;
    logic [1:0]             bresp_q, rresp_q;
    logic [31:0]            rdata_q;
    logic [NUM_CTRL*32-1:0] ctrl_q, ctrl_d;
    logic [NUM_CTRL-1:0]    pulse_q, pulse_d;
    logic [31:0]            rd_data_d;
    logic [1:0]             rd_resp_d;
    logic [31:0]            ar_idx, wr_idx;
    logic                   aw_hs, w_hs, ar_hs, commit, wr_ok;
    logic                   unused_addr_lsbs;

    assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = en_q & ~aw_full_q;
    assign S_AXI_WREADY  = en_q & ~w_full_q;
    assign S_AXI_ARREADY = en_q & ~rvalid_q;
    assign aw_hs         = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs          = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs         = S_AXI_ARVALID & S_AXI_ARREADY;

    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign ctrl_out      = ctrl_q;
    assign ctrl_wr_pulse = pulse_q;

    // Read decode: sampled into the R registers on the AR handshake edge
    always_comb begin
        rd_data_d = '0;
        rd_resp_d = RESP_SLVERR;
        ar_idx    = 32'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);
        case (decode(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]))
            SEL_STATUS: begin
                rd_resp_d = RESP_OKAY;
                for (int k = 0; k < NUM_STATUS; k++)
                    if (ar_idx == 32'(k)) rd_data_d = status_in[32*k +: 32];
            end
            SEL_CTRL: begin
                rd_resp_d = RESP_OKAY;
                for (int k = 0; k < NUM_CTRL; k++)
                    if (ar_idx == CTRL_LO + 32'(k)) rd_data_d = ctrl_q[32*k +: 32];
            end
            SEL_ID: begin
                rd_resp_d = RESP_OKAY;
                rd_data_d = ID_VALUE;
            end
            default: ;
        endcase
    end

    // Commit stage: both holding registers full and no response outstanding
    always_comb begin
        commit  = aw_full_q & w_full_q & ~bvalid_q;
        wr_ok   = (decode(aw_idx_q) == SEL_CTRL);
        wr_idx  = 32'(aw_idx_q);
        ctrl_d  = ctrl_q;
        pulse_d = '0;
        if (commit && wr_ok) begin
            for (int k = 0; k < NUM_CTRL; k++) begin
                if (wr_idx == CTRL_LO + 32'(k)) begin
                    pulse_d[k] = 1'b1;
                    for (int b = 0; b < 4; b++)
                        if (w_strb_q[b]) ctrl_d[32*k+8*b +: 8] = w_data_q[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            en_q      <= 1'b0;
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            ctrl_q    <= CTRL_RESET;
            pulse_q   <= '0;
        end else begin
            en_q    <= 1'b1;
            ctrl_q  <= ctrl_d;
            pulse_q <= pulse_d;
            if (commit) begin
                aw_full_q <= 1'b0;
                w_full_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_hs) aw_full_q <= 1'b1;
                if (w_hs)  w_full_q  <= 1'b1;
                if (bvalid_q && S_AXI_BREADY) bvalid_q <= 1'b0;
            end
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data_d;
                rresp_q  <= rd_resp_d;
            end else if (rvalid_q && S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Holding-register payloads are only meaningful while their full flag is set
    always_ff @(posedge S_AXI_ACLK) begin
        if (aw_hs) aw_idx_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
        if (w_hs) begin
            w_data_q <= S_AXI_WDATA;
            w_strb_q <= S_AXI_WSTRB;
        end
    end

endmodule

// File: tb/tb_ntps_regbank_axi_slave.sv
// Directed bench for ntps_regbank_axi_slave: reset, write ordering, strobes,
// error responses, backpressure and reset during a write.
module tb_ntps_regbank_axi_slave;

    localparam int NS = 16;
    localparam int NC = 8;
    localparam logic [NC*32-1:0] CRST = {32'hC0DE0007, 32'hC0DE0006, 32'hC0DE0005, 32'hC0DE0004,
                                         32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};
    localparam logic [31:0] IDV = 32'h11a6ebf9;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NS*32-1:0]  status_in;
    logic [NC*32-1:0]  ctrl_out;
    logic [NC-1:0]     ctrl_wr_pulse;
    logic [7:0]        AWADDR = '0, ARADDR = '0;
    logic              AWVALID = 1'b0, WVALID = 1'b0, ARVALID = 1'b0;
    logic              BREADY = 1'b1, RREADY = 1'b1;
    logic [31:0]       WDATA = '0;
    logic [3:0]        WSTRB = '0;
    logic              AWREADY, WREADY, ARREADY, BVALID, RVALID;
    logic [1:0]        BRESP, RRESP;
    logic [31:0]       RDATA;

    int n_assert = 0;
    int n_fail   = 0;
    logic [NC*32-1:0] exp_ctrl;
    logic [31:0] rd_d;
    logic [1:0]  rd_r;
    logic        bad;

    ntps_regbank_axi_slave #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(8), .NUM_STATUS(NS), .NUM_CTRL(NC),
        .CTRL_BASE(32), .CTRL_RESET(CRST), .ID_VALUE(IDV)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .status_in(status_in), .ctrl_out(ctrl_out), .ctrl_wr_pulse(ctrl_wr_pulse),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
        .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
        .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge; returns at the negedge following the later handshake edge.
    task automatic drive_aw_w(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                              input int aw_d, input int w_d);
        logic aw_done, w_done, aw_now, w_now;
        aw_done = 1'b0;
        w_done  = 1'b0;
        for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
            if (c == aw_d) begin AWADDR = addr; AWVALID = 1'b1; end
            if (c == w_d)  begin WDATA = data; WSTRB = strb; WVALID = 1'b1; end
            aw_now = AWVALID && AWREADY;
            w_now  = WVALID && WREADY;
            @(negedge clk);
            if (aw_now) begin AWVALID = 1'b0; aw_done = 1'b1; end
            if (w_now)  begin WVALID = 1'b0;  w_done = 1'b1; end
        end
        if (!(aw_done && w_done)) begin
            chk("aw_w_handshake_timeout", 256'(0), 256'(1));
            AWVALID = 1'b0;
            WVALID  = 1'b0;
        end
    endtask

    task automatic wr_chk(input string tag, input logic [7:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_d, input int w_d,
                          input logic [1:0] exp_resp, input logic [NC-1:0] exp_pulse,
                          input logic [NC*32-1:0] exp_c);
        drive_aw_w(addr, data, strb, aw_d, w_d);
        chk({tag, "_bvalid_early"}, 256'(BVALID), 256'(0));
        @(negedge clk);
        chk({tag, "_bvalid"}, 256'(BVALID), 256'(1));
        chk({tag, "_bresp"}, 256'(BRESP), 256'(exp_resp));
        chk({tag, "_pulse"}, 256'(ctrl_wr_pulse), 256'(exp_pulse));
        chk({tag, "_ctrl"}, 256'(ctrl_out), 256'(exp_c));
        @(negedge clk);
        chk({tag, "_pulse_end"}, 256'(ctrl_wr_pulse), 256'(0));
        chk({tag, "_bvalid_end"}, 256'(BVALID), 256'(0));
    endtask

    task automatic rd(input string tag, input logic [7:0] addr, output logic [31:0] d, output logic [1:0] r);
        logic ok;
        ok = 1'b0;
        ARADDR  = addr;
        ARVALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (ARREADY) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) chk({tag, "_ar_timeout"}, 256'(0), 256'(1));
        @(negedge clk);
        ARVALID = 1'b0;
        chk({tag, "_rvalid"}, 256'(RVALID), 256'(1));
        d = RDATA;
        r = RRESP;
        @(negedge clk);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp_d, input logic [1:0] exp_r);
        logic [31:0] d;
        logic [1:0]  r;
        rd(tag, addr, d, r);
        chk({tag, "_rdata"}, 256'(d), 256'(exp_d));
        chk({tag, "_rresp"}, 256'(r), 256'(exp_r));
    endtask

    initial begin
        for (int i = 0; i < NS; i++) status_in[32*i +: 32] = 32'h5A000000 + 32'(i);
        exp_ctrl = CRST;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_awready", 256'(AWREADY), 256'(0));
        chk("rst_arready", 256'(ARREADY), 256'(0));
        chk("rst_bvalid", 256'(BVALID), 256'(0));
        chk("rst_rvalid", 256'(RVALID), 256'(0));
        chk("rst_rdata", 256'(RDATA), 256'(0));
        chk("rst_ctrl", 256'(ctrl_out), 256'(CRST));
        chk("rst_pulse", 256'(ctrl_wr_pulse), 256'(0));
        rst_n = 1'b1;
        #1;
        chk("rel_ready_first", 256'({AWREADY, WREADY, ARREADY}), 256'(3'b000));
        @(negedge clk);
        chk("rel_ready_next", 256'({AWREADY, WREADY, ARREADY}), 256'(3'b111));

        rd_chk("id_read", 8'hFC, IDV, 2'b00);
        for (int k = 0; k < NC; k++)
            rd_chk($sformatf("ctrl_rst_rd%0d", k), 8'(8'h80 + 4 * k), CRST[32*k +: 32], 2'b00);

        // Write ordering
        exp_ctrl[31:0] = 32'hA5A50001;
        wr_chk("wr_w_first", 8'h80, 32'hA5A50001, 4'hF, 2, 0, 2'b00, 8'h01, exp_ctrl);
        wr_chk("wr_aw_first", 8'h80, 32'hA5A50001, 4'hF, 0, 2, 2'b00, 8'h01, exp_ctrl);
        wr_chk("wr_together", 8'h80, 32'hA5A50001, 4'hF, 0, 0, 2'b00, 8'h01, exp_ctrl);

        // Byte strobes on control word 1
        exp_ctrl[63:32] = 32'h11223344;
        wr_chk("strb_full", 8'h84, 32'h11223344, 4'hF, 0, 0, 2'b00, 8'h02, exp_ctrl);
        exp_ctrl[63:32] = 32'h11FF33FF;
        wr_chk("strb_0101", 8'h84, 32'hFFFFFFFF, 4'b0101, 0, 0, 2'b00, 8'h02, exp_ctrl);
        rd_chk("strb_rd", 8'h84, 32'h11FF33FF, 2'b00);
        wr_chk("strb_none", 8'h84, 32'h00000000, 4'b0000, 1, 0, 2'b00, 8'h02, exp_ctrl);
        rd_chk("strb_none_rd", 8'h84, 32'h11FF33FF, 2'b00);

        // Error responses and status reads
        wr_chk("wr_status", 8'h00, 32'h12345678, 4'hF, 0, 0, 2'b10, 8'h00, exp_ctrl);
        rd_chk("rd_status5", 8'h14, 32'h5A000005, 2'b00);
        rd_chk("rd_unmapped", 8'h50, 32'h00000000, 2'b10);
        wr_chk("wr_id", 8'hFC, 32'hDEADBEEF, 4'hF, 0, 0, 2'b10, 8'h00, exp_ctrl);
        rd_chk("id_after_wr", 8'hFC, IDV, 2'b00);

        // B-channel backpressure
        BREADY = 1'b0;
        drive_aw_w(8'h88, 32'h00001111, 4'hF, 0, 0);
        @(negedge clk);
        exp_ctrl[95:64] = 32'h00001111;
        chk("bp_first_bvalid", 256'(BVALID), 256'(1));
        chk("bp_first_ctrl", 256'(ctrl_out), 256'(exp_ctrl));
        drive_aw_w(8'h8C, 32'h00002222, 4'hF, 0, 0);
        chk("bp_ready_drop", 256'({AWREADY, WREADY}), 256'(2'b00));
        bad = 1'b0;
        repeat (9) begin
            @(negedge clk);
            if (!BVALID || AWREADY || WREADY || ctrl_out !== exp_ctrl || ctrl_wr_pulse !== '0) bad = 1'b1;
        end
        chk("bp_hold", 256'(bad), 256'(0));
        BREADY = 1'b1;
        @(negedge clk);
        chk("bp_after_b_bvalid", 256'(BVALID), 256'(0));
        chk("bp_after_b_ctrl", 256'(ctrl_out), 256'(exp_ctrl));
        @(negedge clk);
        exp_ctrl[127:96] = 32'h00002222;
        chk("bp_second_bvalid", 256'(BVALID), 256'(1));
        chk("bp_second_pulse", 256'(ctrl_wr_pulse), 256'(8'h08));
        chk("bp_second_ctrl", 256'(ctrl_out), 256'(exp_ctrl));
        @(negedge clk);
        chk("bp_second_done", 256'(BVALID), 256'(0));

        // R-channel backpressure
        RREADY  = 1'b0;
        ARADDR  = 8'h0C;
        ARVALID = 1'b1;
        chk("rbp_arready", 256'(ARREADY), 256'(1));
        @(negedge clk);
        chk("rbp_rvalid", 256'(RVALID), 256'(1));
        chk("rbp_rdata", 256'(RDATA), 256'(32'h5A000003));
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            status_in[96 +: 32] = 32'h77000000 + 32'(i);
            @(negedge clk);
            if (RDATA !== 32'h5A000003 || ARREADY || !RVALID) bad = 1'b1;
        end
        chk("rbp_stable", 256'(bad), 256'(0));
        ARVALID = 1'b0;
        RREADY  = 1'b1;
        status_in[96 +: 32] = 32'h5A000003;
        @(negedge clk);
        chk("rbp_released", 256'(RVALID), 256'(0));

        // Reset between AW and W
        AWADDR  = 8'h90;
        AWVALID = 1'b1;
        @(negedge clk);
        AWVALID = 1'b0;
        chk("mid_aw_full", 256'(AWREADY), 256'(0));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", 256'(ctrl_out), 256'(CRST));
        chk("mid_rst_ready", 256'({AWREADY, WREADY, ARREADY}), 256'(3'b000));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_ready", 256'({AWREADY, WREADY}), 256'(2'b11));
        WDATA  = 32'hDEADBEEF;
        WSTRB  = 4'hF;
        WVALID = 1'b1;
        @(negedge clk);
        WVALID = 1'b0;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (BVALID || ctrl_wr_pulse !== '0) bad = 1'b1;
        end
        chk("mid_w_alone_no_commit", 256'(bad), 256'(0));
        chk("mid_w_alone_ctrl", 256'(ctrl_out), 256'(CRST));
        chk("mid_w_alone_aw_ready", 256'(AWREADY), 256'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
